// File: rtl/slave_mem_core_if.sv
// rtl/slave_mem_core_if.sv - bus-side handshake bundle between a master core and slave_mem_core
interface slave_mem_core_if;
  logic [15:0] addr_from_si;
  logic        addr_req_from_si;
  logic [7:0]  write_data_from_si;
  logic        write_data_req_from_si;
  logic        read_data_req_from_si;
  logic        ok_response_to_si;
  logic        addr_error_to_si;
  logic [7:0]  read_data_to_si;
  logic        req_done_to_si;

  modport master (
    output addr_from_si, addr_req_from_si, write_data_from_si,
           write_data_req_from_si, read_data_req_from_si,
    input  ok_response_to_si, addr_error_to_si, read_data_to_si, req_done_to_si
  );

  modport slave (
    input  addr_from_si, addr_req_from_si, write_data_from_si,
           write_data_req_from_si, read_data_req_from_si,
    output ok_response_to_si, addr_error_to_si, read_data_to_si, req_done_to_si
  );
endinterface

// File: rtl/slave_mem_core.sv
// rtl/slave_mem_core.sv - byte-addressable memory responder with four-phase address/data handshakes
module slave_mem_core #(
  parameter logic [1:0] SLAVE_ID      = 2'b01,
  parameter int         MEM_DEPTH     = 4096,
  parameter int         WRITE_LATENCY = 1,
  parameter int         READ_LATENCY  = 2
) (
  input  logic             clk,
  input  logic             reset,
  slave_mem_core_if.slave  bus,
  output logic             busy
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDR_ACK, ERR_ACK, DATA_WAIT, EXEC, DONE_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] off_q, off_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        mem_we;
  logic        addr_valid;
  logic        data_req_active;
  logic [AW-1:0] idx;

  logic [7:0] mem [MEM_DEPTH];

  // Offsets beyond MEM_DEPTH never get past decode, so the low AW bits index safely.
  assign idx = off_q[AW-1:0];

  assign addr_valid = bus.addr_from_si[15]
                   && (bus.addr_from_si[14:13] == SLAVE_ID)
                   && ({20'd0, bus.addr_from_si[11:0]} < 32'(MEM_DEPTH));

  // The data request that matters in DONE_ACK is the one that matched the latched R/W bit.
  assign data_req_active = rw_q ? bus.write_data_req_from_si : bus.read_data_req_from_si;

  // State and handshake registers; memory contents are deliberately outside this reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      off_q   <= 12'd0;
      rw_q    <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      cnt_q   <= 4'd0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Next-state, handshake and datapath decisions for every state.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    err_d   = err_q;
    done_d  = done_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.addr_req_from_si) begin
          off_d = bus.addr_from_si[11:0];
          rw_d  = bus.addr_from_si[12];
          if (addr_valid) begin
            ok_d    = 1'b1;
            state_d = ADDR_ACK;
          end else begin
            err_d   = 1'b1;
            state_d = ERR_ACK;
          end
        end
      end
      ADDR_ACK: begin
        if (!bus.addr_req_from_si) begin
          ok_d    = 1'b0;
          state_d = DATA_WAIT;
        end
      end
      ERR_ACK: begin
        if (!bus.addr_req_from_si) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      DATA_WAIT: begin
        if (rw_q && bus.write_data_req_from_si) begin
          wdata_d = bus.write_data_from_si;
          cnt_d   = 4'(WRITE_LATENCY);
          state_d = EXEC;
        end else if (!rw_q && bus.read_data_req_from_si) begin
          cnt_d   = 4'(READ_LATENCY);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (rw_q) mem_we = 1'b1;
          else      rdata_d = mem[idx];
          done_d  = 1'b1;
          state_d = DONE_ACK;
        end
      end
      DONE_ACK: begin
        if (!data_req_active) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte write on the commit cycle; a reset that pulls the FSM out of EXEC cancels it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  assign bus.ok_response_to_si = ok_q;
  assign bus.addr_error_to_si  = err_q;
  assign bus.req_done_to_si    = done_q;
  assign bus.read_data_to_si   = rdata_q;
  assign busy                  = (state_q != IDLE);

endmodule
